// File: rtl/baud_tick_gen.sv
// baud_tick_gen: programmable oversampling baud tick generator (tick every D clocks, bit_tick every OVERSAMPLE ticks); `BAUD_FRAC_EN adds fractional divisor (div_frac_in); ports clk, rst, enable, div_wr, div_in, sync -> tick, bit_tick
module baud_tick_gen #(
  parameter int FREQUENCY   = 100000000,
  parameter int BAUD_RATE   = 9600,
  parameter int OVERSAMPLE  = 16,
  parameter int DIV_WIDTH   = 16,
`ifdef BAUD_FRAC_EN
  parameter int FRAC_BITS   = 4,
`endif
  parameter int DEFAULT_DIV = FREQUENCY / (BAUD_RATE * OVERSAMPLE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 div_wr,
  input  logic [DIV_WIDTH-1:0] div_in,
`ifdef BAUD_FRAC_EN
  input  logic [FRAC_BITS-1:0] div_frac_in,
`endif
  input  logic                 sync,
  output logic                 tick,
  output logic                 bit_tick
);
  localparam int SW = $clog2(OVERSAMPLE);
`ifdef BAUD_FRAC_EN
  localparam int CW = DIV_WIDTH + 1;
`else
  localparam int CW = DIV_WIDTH;
`endif
  localparam logic [SW-1:0] SUB_MAX  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SUB_HALF = SW'(OVERSAMPLE / 2);
  if (DEFAULT_DIV < 2 || (DEFAULT_DIV >> DIV_WIDTH) != 0) begin : g_bad_div
    $error("baud_tick_gen: DEFAULT_DIV out of range");
  end
  if (OVERSAMPLE < 2 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_os
    $error("baud_tick_gen: OVERSAMPLE must be a power of two >= 2");
  end
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [CW-1:0]        cnt_q, cnt_d, last;
  logic [SW-1:0]        sub_q, sub_d;
  logic                 tick_q, tick_d, bit_tick_q, bit_tick_d, term, ext;
`ifdef BAUD_FRAC_EN
  logic [FRAC_BITS-1:0] frac_q, frac_d, acc_q, acc_d;
  logic                 carry_q, carry_d;
  assign ext = carry_q;
`else
  assign ext = 1'b0;
`endif
  // a latched carry stretches the current period by one clock
  assign last = CW'(div_q) - CW'(1) + CW'(ext);
  assign term = cnt_q == last;
  always_comb begin
    div_d      = div_q;
    cnt_d      = cnt_q;
    sub_d      = sub_q;
    tick_d     = 1'b0;
    bit_tick_d = 1'b0;
    if (div_wr) begin
      div_d = (div_in < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div_in;
      cnt_d = '0;
      sub_d = '0;
    end else if (sync) begin
      cnt_d = '0;
      sub_d = SUB_HALF;
    end else if (enable) begin
      cnt_d      = term ? '0 : cnt_q + CW'(1);
      tick_d     = term;
      sub_d      = term ? ((sub_q == SUB_MAX) ? '0 : sub_q + SW'(1)) : sub_q;
      bit_tick_d = term && (sub_q == SUB_MAX);
    end
  end
`ifdef BAUD_FRAC_EN
  always_comb begin
    frac_d  = div_wr ? div_frac_in : frac_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    if (div_wr) begin
      acc_d   = '0;
      carry_d = 1'b0;
    end else if (!sync && enable && term) begin
      {carry_d, acc_d} = (FRAC_BITS + 1)'(acc_q) + (FRAC_BITS + 1)'(frac_q);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      frac_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      frac_q  <= frac_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= DIV_WIDTH'(DEFAULT_DIV);
      cnt_q      <= '0;
      sub_q      <= '0;
      tick_q     <= 1'b0;
      bit_tick_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      sub_q      <= sub_d;
      tick_q     <= tick_d;
      bit_tick_q <= bit_tick_d;
    end
  end
  assign tick     = tick_q;
  assign bit_tick = bit_tick_q;
endmodule

// File: tb/tb_baud_tick_gen.sv
// tb_baud_tick_gen: directed self-checking bench for baud_tick_gen
module tb_baud_tick_gen;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        div_wr = 1'b0;
  logic [15:0] div_in = '0;
  logic        sync = 1'b0;
  logic        tick, bit_tick;
  int          tests = 0;
  int          fails = 0;
  int          edges = 0;
  int          n;
`ifdef BAUD_FRAC_EN
  logic [3:0]  div_frac_in = '0;
`endif
  baud_tick_gen dut (
    .clk(clk), .rst(rst), .enable(enable), .div_wr(div_wr), .div_in(div_in),
`ifdef BAUD_FRAC_EN
    .div_frac_in(div_frac_in),
`endif
    .sync(sync), .tick(tick), .bit_tick(bit_tick)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
    edges++;
  endtask
  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic wait_tick(output int c);
    c = 0;
    do begin
      step();
      c++;
    end while (tick !== 1'b1 && c < 70000);
  endtask
  task automatic wait_bit();
    int c;
    c = 0;
    do begin
      step();
      c++;
    end while (bit_tick !== 1'b1 && c < 70000);
  endtask
  task automatic load(input int d);
    div_wr = 1'b1;
    div_in = 16'(d);
    step();
    chk("load_no_tick", int'(tick), 0);
    div_wr = 1'b0;
    edges = 0;
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_tick", int'(tick), 0);
      chk("rst_bit", int'(bit_tick), 0);
    end
    rst = 1'b0;
    edges = 0;
    wait_tick(n);
    chk("def_tick1", n, 651);
    chk("def_tick1_nobit", int'(bit_tick), 0);
    step();
    chk("def_tick_width", int'(tick), 0);
    wait_tick(n);
    chk("def_tick2_edge", edges, 1302);
    wait_bit();
    chk("def_bit_edge", edges, 10416);
    chk("def_bit_with_tick", int'(tick), 1);
    load(4);
    wait_tick(n);
    chk("d4_tick1", n, 4);
    wait_tick(n);
    chk("d4_tick2", n, 4);
    wait_bit();
    chk("d4_bit_edge", edges, 64);
    load(0);
    wait_tick(n);
    chk("d0_tick1", n, 2);
    wait_tick(n);
    chk("d0_tick2", n, 2);
    load(1);
    wait_tick(n);
    chk("d1_tick1", n, 2);
    wait_tick(n);
    chk("d1_tick2", n, 2);
    load(4);
    steps(9);
    sync = 1'b1;
    step();
    chk("sync_no_tick", int'(tick), 0);
    sync = 1'b0;
    edges = 0;
    wait_tick(n);
    chk("sync_tick1", n, 4);
    wait_tick(n);
    chk("sync_tick2", n, 4);
    wait_bit();
    chk("sync_bit_edge", edges, 32);
    load(4);
    wait_tick(n);
    edges = 0;
    steps(2);
    enable = 1'b0;
    steps(10);
    chk("dis_no_tick", int'(tick), 0);
    enable = 1'b1;
    wait_tick(n);
    chk("dis_period", edges, 14);
    wait_tick(n);
    chk("dis_after", n, 4);
    steps(3);
    div_wr = 1'b1;
    div_in = 16'd4;
    step();
    chk("wr_on_term_no_tick", int'(tick), 0);
    div_wr = 1'b0;
    wait_tick(n);
    chk("wr_on_term_next", n, 4);
    steps(3);
    sync = 1'b1;
    step();
    chk("sync_on_term_no_tick", int'(tick), 0);
    sync = 1'b0;
    wait_tick(n);
    chk("sync_on_term_next", n, 4);
    div_wr = 1'b1;
    sync = 1'b1;
    div_in = 16'd4;
    step();
    div_wr = 1'b0;
    sync = 1'b0;
    edges = 0;
    wait_bit();
    chk("wr_beats_sync_bit", edges, 64);
`ifdef BAUD_FRAC_EN
    begin
      int exp_p [7] = '{4, 4, 5, 4, 5, 4, 5};
      div_frac_in = 4'd8;
      load(4);
      for (int i = 0; i < 7; i++) begin
        wait_tick(n);
        chk($sformatf("frac_p%0d", i), n, exp_p[i]);
      end
      load(4);
      for (int i = 0; i < 3; i++) begin
        wait_tick(n);
        chk($sformatf("frac_re_p%0d", i), n, exp_p[i]);
      end
    end
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
